// File: rtl/matrix_result_display.sv
// Seven-segment viewer for the 2x2 signed matrix multiplier result: shows C11..C22 one at a time
// with a programmable dwell, decimal point as minus sign, and an "E" glyph for operand-range errors.
module matrix_result_display #(
  parameter int DWELL_CYCLES = 10000000,
  parameter int CNT_W        = 24,
  parameter int LOOP         = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [15:0] res_data,
  input  logic        res_error,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic [1:0]  elem_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic             LOOP_EN    = (LOOP != 0);
  localparam logic [6:0]       GLYPH_E    = 7'h79;

  // Sign/magnitude decode of one signed nibble: {dp, segments}; -8 shows as 8 with dp lit.
  function automatic logic [7:0] decode_elem(input logic [3:0] val);
    logic [3:0] mag;
    logic [6:0] glyph;
    if (val[3]) begin
      mag = 4'd0 - val;
    end else begin
      mag = val;
    end
    case (mag)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      default: glyph = 7'h00;
    endcase
    return {val[3], glyph};
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [1:0]        elem_r, elem_s;
  logic [15:0]       data_r, data_s;
  logic              done_s;
  logic              ready_s;
  logic              xfer_s;
  logic              expire_s;
  logic [3:0]        elem_val_s;
  logic [7:0]        decoded_s;
  logic [6:0]        seg_s;
  logic              dp_s;

  assign ready_s   = (state_r == IDLE) || (LOOP_EN && (state_r == SHOW));
  assign xfer_s    = res_valid && ready_s;
  assign expire_s  = (cnt_r == DWELL_LAST);
  assign res_ready = ready_s;
  assign elem_idx  = elem_r;

  // Next-state, dwell counter and capture logic; a transfer outranks dwell expiry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    elem_s  = elem_r;
    data_s  = data_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          data_s  = res_data;
          cnt_s   = CNT_ZERO;
          elem_s  = 2'd0;
          state_s = res_error ? ERR : SHOW;
        end else begin
          elem_s  = 2'd0;
        end
      end
      SHOW: begin
        if (xfer_s) begin
          data_s  = res_data;
          cnt_s   = CNT_ZERO;
          elem_s  = 2'd0;
          state_s = res_error ? ERR : SHOW;
        end else if (expire_s) begin
          cnt_s = CNT_ZERO;
          if (elem_r != 2'd3) begin
            elem_s = elem_r + 2'd1;
          end else if (LOOP_EN) begin
            elem_s = 2'd0;
            done_s = 1'b1;
          end else begin
            elem_s  = 2'd0;
            done_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ERR: begin
        elem_s = 2'd0;
        if (expire_s) begin
          cnt_s   = CNT_ZERO;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        elem_s  = 2'd0;
      end
    endcase
  end

  // Display decode from next-state values so the first digit appears the cycle after the handshake.
  always_comb begin
    case (elem_s)
      2'd0:    elem_val_s = data_s[3:0];
      2'd1:    elem_val_s = data_s[7:4];
      2'd2:    elem_val_s = data_s[11:8];
      2'd3:    elem_val_s = data_s[15:12];
      default: elem_val_s = data_s[3:0];
    endcase
    decoded_s = decode_elem(elem_val_s);
    case (state_s)
      IDLE: begin
        seg_s = 7'h00;
        dp_s  = 1'b0;
      end
      SHOW: begin
        seg_s = decoded_s[6:0];
        dp_s  = decoded_s[7];
      end
      ERR: begin
        seg_s = GLYPH_E;
        dp_s  = 1'b0;
      end
      default: begin
        seg_s = 7'h00;
        dp_s  = 1'b0;
      end
    endcase
  end

  // State, counter, capture and registered display outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      elem_r  <= 2'd0;
      data_r  <= 16'h0000;
      seg     <= 7'h00;
      seg_dp  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      elem_r  <= elem_s;
      data_r  <= data_s;
      seg     <= seg_s;
      seg_dp  <= dp_s;
      busy    <= (state_s != IDLE);
      done    <= done_s;
    end
  end

endmodule

// File: tb/tb_matrix_result_display.sv
// Directed bench for matrix_result_display: three instances cover DWELL=4/LOOP=0,
// DWELL=3/LOOP=1 and DWELL=1/LOOP=0; outputs sampled on the falling edge.
module tb_matrix_result_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        va, ea, ra, dp_a, busy_a, done_a;
  logic [15:0] da;
  logic [6:0]  seg_a;
  logic [1:0]  idx_a;
  logic        vb, eb, rb, dp_b, busy_b, done_b;
  logic [15:0] db;
  logic [6:0]  seg_b;
  logic [1:0]  idx_b;
  logic        vc, ec, rc, dp_c, busy_c, done_c;
  logic [15:0] dc;
  logic [6:0]  seg_c;
  logic [1:0]  idx_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected digits for packed result 0x0F21: 1, 2, -1, 0
  logic [6:0] exp_seg [4] = '{7'h06, 7'h5B, 7'h06, 7'h3F};
  logic       exp_dp  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  matrix_result_display #(.DWELL_CYCLES(4), .CNT_W(24), .LOOP(0)) u_a (
    .clk(clk), .reset(reset), .res_valid(va), .res_ready(ra), .res_data(da), .res_error(ea),
    .seg(seg_a), .seg_dp(dp_a), .elem_idx(idx_a), .busy(busy_a), .done(done_a));

  matrix_result_display #(.DWELL_CYCLES(3), .CNT_W(4), .LOOP(1)) u_b (
    .clk(clk), .reset(reset), .res_valid(vb), .res_ready(rb), .res_data(db), .res_error(eb),
    .seg(seg_b), .seg_dp(dp_b), .elem_idx(idx_b), .busy(busy_b), .done(done_b));

  matrix_result_display #(.DWELL_CYCLES(1), .CNT_W(24), .LOOP(0)) u_c (
    .clk(clk), .reset(reset), .res_valid(vc), .res_ready(rc), .res_data(dc), .res_error(ec),
    .seg(seg_c), .seg_dp(dp_c), .elem_idx(idx_c), .busy(busy_c), .done(done_c));

  // Vector layout: {seg[6:0], dp, elem_idx[1:0], busy, done, res_ready}
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    va = 1'b0; ea = 1'b0; da = 16'h0000;
    vb = 1'b0; eb = 1'b0; db = 16'h0000;
    vc = 1'b0; ec = 1'b0; dc = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_a", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    chk("rst_b", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;

    // A: show 0x0F21 once; 0x7777 held valid during SHOW must wait for IDLE
    va = 1'b1; da = 16'h0F21;
    @(negedge clk);
    da = 16'h7777;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("a_show_c%0d", k), {seg_a, dp_a, idx_a, busy_a, done_a, ra},
          {exp_seg[(k-1)/4], exp_dp[(k-1)/4], 2'((k-1)/4), 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    chk("a_done", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    va = 1'b0;
    chk("a_recapture", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h07, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
    repeat (8) @(negedge clk);
    chk("a_elem2", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h07, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    chk("a_rst_mid", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;

    // A: error result shows "E" for the dwell, then done
    va = 1'b1; ea = 1'b1; da = 16'h1234;
    @(negedge clk);
    va = 1'b0; ea = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("a_err_c%0d", k), {seg_a, dp_a, idx_a, busy_a, done_a, ra},
          {7'h79, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    chk("a_err_done", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("a_done_1cyc", {seg_a, dp_a, idx_a, busy_a, done_a, ra}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});

    // B: LOOP=1, DWELL=3 with 0x8000 (C22 = -8)
    vb = 1'b1; db = 16'h8000;
    @(negedge clk);
    vb = 1'b0;
    chk("b_c11", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h3F, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    repeat (9) @(negedge clk);
    chk("b_c22_neg8", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h7F, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    chk("b_wrap", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h3F, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    vb = 1'b1; db = 16'h0001;
    @(negedge clk);
    vb = 1'b0;
    chk("b_xfer_on_expiry", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h06, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    chk("b_dwell_restart", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h06, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("b_advance", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h3F, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1});
    vb = 1'b1; eb = 1'b1;
    @(negedge clk);
    vb = 1'b0; eb = 1'b0;
    chk("b_show_to_err", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h79, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    chk("b_err_done", {seg_b, dp_b, idx_b, busy_b, done_b, rb}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});

    // C: DWELL=1 advances every cycle
    vc = 1'b1; dc = 16'h0F21;
    @(negedge clk);
    vc = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("c_show_c%0d", k), {seg_c, dp_c, idx_c, busy_c, done_c, rc},
          {exp_seg[k-1], exp_dp[k-1], 2'(k-1), 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    chk("c_done", {seg_c, dp_c, idx_c, busy_c, done_c, rc}, {7'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
